// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, channel FSM states and the W-channel beat payload.
package axi_lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_AW,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } w_beat_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word-addressed storage: byte-enable write port, registered read port, async clear.
module axi_lite_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                rd_en,
    input  logic                rd_hit,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage words with per-byte write enables; whole array cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read data captured on request; a decode miss returns zero. Sees pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_hit ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave exposing a small word memory window at BASE_ADDR.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = C_S_AXI_ADDR_WIDTH'(32'h10000080),
    parameter int unsigned                   MEM_DEPTH          = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * MEM_DEPTH);

    w_state_t            w_state;
    r_state_t            r_state;
    logic [ADDR_W-1:0]   aw_addr_q;
    w_beat_t             w_beat_q;

    logic                aw_hs_c;
    logic                w_hs_c;
    logic                ar_hs_c;
    logic                commit_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    w_beat_t             wr_beat_c;
    logic [ADDR_W-1:0]   wr_off_c;
    logic [ADDR_W-1:0]   rd_off_c;
    logic                wr_hit_c;
    logic                rd_hit_c;
    logic [IDX_W-1:0]    wr_idx_c;
    logic [IDX_W-1:0]    rd_idx_c;

    logic                unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_off_c, rd_off_c};

    // Handshakes, held-vs-live write operand select, address decode and commit strobe.
    always_comb begin
        aw_hs_c   = S_AXI_AWVALID & S_AXI_AWREADY;
        w_hs_c    = S_AXI_WVALID & S_AXI_WREADY;
        ar_hs_c   = S_AXI_ARVALID & S_AXI_ARREADY;

        wr_addr_c = (w_state == W_WAIT_W) ? aw_addr_q : S_AXI_AWADDR;
        wr_beat_c = w_beat_q;
        if (w_state != W_WAIT_AW) begin
            wr_beat_c.data = S_AXI_WDATA;
            wr_beat_c.strb = S_AXI_WSTRB;
        end

        wr_off_c  = wr_addr_c - BASE_ADDR;
        rd_off_c  = S_AXI_ARADDR - BASE_ADDR;
        wr_hit_c  = (wr_addr_c >= BASE_ADDR) && (wr_off_c < SPAN);
        rd_hit_c  = (S_AXI_ARADDR >= BASE_ADDR) && (rd_off_c < SPAN);
        wr_idx_c  = wr_off_c[IDX_W+1:2];
        rd_idx_c  = rd_off_c[IDX_W+1:2];

        commit_c  = 1'b0;
        case (w_state)
            W_IDLE:    commit_c = aw_hs_c & w_hs_c;
            W_WAIT_W:  commit_c = w_hs_c;
            W_WAIT_AW: commit_c = aw_hs_c;
            default:   commit_c = 1'b0;
        endcase
    end

    // Write channel FSM: collect AW and W in any order, commit, then hold the response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= OKAY;
            aw_addr_q     <= '0;
            w_beat_q      <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b1;
                    if (aw_hs_c && !w_hs_c) begin
                        aw_addr_q     <= S_AXI_AWADDR;
                        S_AXI_AWREADY <= 1'b0;
                        w_state       <= W_WAIT_W;
                    end else if (w_hs_c && !aw_hs_c) begin
                        w_beat_q.data <= S_AXI_WDATA;
                        w_beat_q.strb <= S_AXI_WSTRB;
                        S_AXI_WREADY  <= 1'b0;
                        w_state       <= W_WAIT_AW;
                    end
                end
                W_WAIT_W, W_WAIT_AW: begin
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase

            if (commit_c) begin
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= wr_hit_c ? OKAY : SLVERR;
                w_state       <= W_RESP;
            end
        end
    end

    // Read channel FSM: accept one address, then hold the registered response until taken.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs_c) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RRESP   <= rd_hit_c ? OKAY : SLVERR;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    axi_lite_mem_array #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .wr_en   (commit_c & wr_hit_c),
        .wr_idx  (wr_idx_c),
        .wr_data (wr_beat_c.data),
        .wr_strb (wr_beat_c.strb),
        .rd_en   (ar_hs_c),
        .rd_hit  (rd_hit_c),
        .rd_idx  (rd_idx_c),
        .rd_data (S_AXI_RDATA)
    );

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Scoreboard bench for axi_lite_slave_mem: queued expected B/R responses checked on acceptance.
module tb_axi_lite_slave_mem;

    localparam logic [31:0] BASE  = 32'h10000080;
    localparam int unsigned DEPTH = 16;
    localparam int          BOUND = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } r_exp_t;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] model [DEPTH];
    logic [1:0]  exp_b_q [$];
    r_exp_t      exp_r_q [$];

    always #5 clk = ~clk;

    axi_lite_slave_mem dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit tb_hit(input logic [31:0] addr);
        return (addr >= BASE) && (addr < BASE + 32'(4 * DEPTH));
    endfunction

    function automatic logic [3:0] tb_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off[5:2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first; 0: together.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int hold);
        logic [1:0] er;
        int         n;
        er = tb_hit(addr) ? 2'b00 : 2'b10;
        exp_b_q.push_back(er);
        if (tb_hit(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[tb_idx(addr)][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        bready = (hold == 0);
        if (lead == 0) begin
            awaddr = addr; awvalid = 1'b1;
            wdata = data; wstrb = strb; wvalid = 1'b1;
            n = 0;
            while (!(awready && wready) && n < BOUND) begin tick(); n++; end
            check("aw_w_ready", 32'({awready, wready}), 32'd3);
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (lead > 0) begin
            wdata = data; wstrb = strb; wvalid = 1'b1;
            n = 0;
            while (!wready && n < BOUND) begin tick(); n++; end
            check("w_ready", 32'(wready), 32'd1);
            tick();
            wvalid = 1'b0;
            check("wready_low_after_w", 32'(wready), 32'd0);
            for (int i = 1; i < lead; i++) begin
                tick();
                check("wready_held_low", 32'(wready), 32'd0);
            end
            awaddr = addr; awvalid = 1'b1;
            n = 0;
            while (!awready && n < BOUND) begin tick(); n++; end
            check("aw_ready", 32'(awready), 32'd1);
            tick();
            awvalid = 1'b0;
        end else begin
            awaddr = addr; awvalid = 1'b1;
            n = 0;
            while (!awready && n < BOUND) begin tick(); n++; end
            check("aw_ready", 32'(awready), 32'd1);
            tick();
            awvalid = 1'b0;
            check("awready_low_after_aw", 32'(awready), 32'd0);
            for (int i = 1; i < -lead; i++) begin
                tick();
                check("awready_held_low", 32'(awready), 32'd0);
            end
            wdata = data; wstrb = strb; wvalid = 1'b1;
            n = 0;
            while (!wready && n < BOUND) begin tick(); n++; end
            check("w_ready", 32'(wready), 32'd1);
            tick();
            wvalid = 1'b0;
        end
        check("b_latency", 32'(bvalid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_hold_valid", 32'(bvalid), 32'd1);
            check("b_hold_resp", 32'(bresp), 32'(er));
            check("b_hold_awready", 32'(awready), 32'd0);
            check("b_hold_wready", 32'(wready), 32'd0);
        end
        bready = 1'b1;
        n = 0;
        while (bvalid && n < BOUND) begin tick(); n++; end
        check("b_accepted", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold, input bit push);
        r_exp_t e;
        int     n;
        e.resp = tb_hit(addr) ? 2'b00 : 2'b10;
        e.data = tb_hit(addr) ? model[tb_idx(addr)] : 32'h0;
        if (push) exp_r_q.push_back(e);
        rready = (hold == 0);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < BOUND) begin tick(); n++; end
        check("ar_ready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check("r_latency", 32'(rvalid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_hold_valid", 32'(rvalid), 32'd1);
            check("r_hold_data", rdata, e.data);
            check("r_hold_resp", 32'(rresp), 32'(e.resp));
            check("r_hold_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        n = 0;
        while (rvalid && n < BOUND) begin tick(); n++; end
        check("r_accepted", 32'(rvalid), 32'd0);
    endtask

    // Pop and compare expected responses at the cycle the DUT response is taken.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (exp_b_q.size() == 0) check("b_unexpected", 32'(bvalid), 32'd0);
            else check("bresp", 32'(bresp), 32'(exp_b_q.pop_front()));
        end
        if (rst_n && rvalid && rready) begin
            if (exp_r_q.size() == 0) begin
                check("r_unexpected", 32'(rvalid), 32'd0);
            end else begin
                r_exp_t e;
                e = exp_r_q.pop_front();
                check("rresp", 32'(rresp), 32'(e.resp));
                check("rdata", rdata, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          lead;
        r_exp_t      e;

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        check("awready_before_edge", 32'(awready), 32'd0);
        tick();
        check("awready_first_edge", 32'(awready), 32'd1);
        check("wready_first_edge", 32'(wready), 32'd1);
        check("arready_first_edge", 32'(arready), 32'd1);

        // Basic write/read, W-before-AW, byte strobes.
        do_write(BASE, 32'h00000001, 4'hF, 0, 0);
        do_read(BASE, 0, 1);
        do_write(BASE + 32'h8, 32'hA5A5A5A5, 4'hF, 3, 0);
        do_read(BASE + 32'h8, 0, 1);
        do_write(BASE + 32'hC, 32'h11223344, 4'hF, -2, 0);
        do_write(BASE + 32'hC, 32'h0000BB00, 4'b0010, 0, 0);
        do_read(BASE + 32'hC, 0, 1);

        // Out-of-window accesses, then confirm every word is intact.
        do_write(32'h100000C0, 32'hDEADBEEF, 4'hF, 0, 0);
        do_write(32'h1000007C, 32'hFEEDFACE, 4'hF, 1, 0);
        do_read(32'h100000C0, 0, 1);
        do_read(32'h1000007C, 0, 1);
        for (int i = 0; i < int'(DEPTH); i++) do_read(BASE + 32'(4 * i), 0, 1);

        // AR accepted on the same edge a write commits to that word: old value returned.
        do_write(BASE + 32'h4, 32'h55667788, 4'hF, 0, 0);
        e.resp = 2'b00;
        e.data = model[1];
        exp_r_q.push_back(e);
        fork
            do_write(BASE + 32'h4, 32'h99AABBCC, 4'hF, 0, 0);
            do_read(BASE + 32'h4, 0, 0);
        join
        do_read(BASE + 32'h4, 0, 1);

        // Random mix, including addresses one word outside each end of the window.
        for (int k = 0; k < 12; k++) begin
            a = BASE + 32'(4 * $urandom_range(0, DEPTH + 1)) - 32'd4;
            lead = int'($urandom_range(0, 4)) - 2;
            do_write(a, $urandom, 4'($urandom_range(0, 15)), lead, 0);
            do_read(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 0, 1);
        end
        for (int i = 0; i < int'(DEPTH); i++) do_read(BASE + 32'(4 * i), 0, 1);

        // Back-pressure on B and R.
        do_write(BASE + 32'h10, 32'hCAFEF00D, 4'hF, 0, 5);
        do_read(BASE + 32'h10, 5, 1);
        do_read(32'h100000C0, 5, 1);

        // Reset while a write response is pending.
        bready = 1'b0;
        awaddr = BASE + 32'h14; awvalid = 1'b1;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bvalid", 32'(bvalid), 32'd0);
        check("async_rst_awready", 32'(awready), 32'd0);
        check("async_rst_arready", 32'(arready), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        tick();
        rst_n = 1'b1;
        bready = 1'b1;
        #1;
        check("rerst_awready_before_edge", 32'(awready), 32'd0);
        tick();
        check("rerst_awready", 32'(awready), 32'd1);
        check("rerst_bvalid", 32'(bvalid), 32'd0);
        do_read(BASE, 0, 1);
        do_read(BASE + 32'h8, 0, 1);
        do_read(BASE + 32'h14, 0, 1);
        do_read(BASE + 32'h3C, 0, 1);

        repeat (2) tick();
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_mem.md
AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (32 only).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h10000080, byte address of word 0.
REQ-004 SHALL have parameter MEM_DEPTH, default 16, number of words (power of 2).
REQ-005 SHALL have one clock and an asynchronous active-low reset; the only clock is S_AXI_ACLK and the only reset is S_AXI_ARESETN.
REQ-006 S_AXI_ACLK  in  1  clock, all logic on rising edge.
REQ-007 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-008 S_AXI_AWADDR  in  ADDR  write address.
REQ-009 S_AXI_AWPROT  in  3  ignored.
REQ-010 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 each  AW handshake.
REQ-011 S_AXI_WDATA  in  DATA  write data.
REQ-012 S_AXI_WSTRB  in  DATA/8  byte enables.
REQ-013 S_AXI_WVALID / S_AXI_WREADY  in / out  1 each  W handshake.
REQ-014 S_AXI_BRESP  out  2  write response.
REQ-015 S_AXI_BVALID / S_AXI_BREADY  out / in  1 each  B handshake.
REQ-016 S_AXI_ARADDR  in  ADDR  read address.
REQ-017 S_AXI_ARPROT  in  3  ignored.
REQ-018 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 each  AR handshake.
REQ-019 S_AXI_RDATA  out  DATA  read data.
REQ-020 S_AXI_RRESP  out  2  read response.
REQ-021 S_AXI_RVALID / S_AXI_RREADY  out / in  1 each  R handshake.

Function
REQ-022 Address decode: hit if BASE_ADDR <= addr < BASE_ADDR+4*MEM_DEPTH; index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
REQ-023 Write FSM states: W_IDLE (AWREADY=1, WREADY=1), W_WAIT_W (AW held, WREADY=1), W_WAIT_AW (W held, AWREADY=1), W_RESP (BVALID=1, both readies 0).
REQ-024 Transitions: W_IDLE on AW and W together -> W_RESP; AW only -> W_WAIT_W; W only -> W_WAIT_AW; wait state on the missing handshake -> W_RESP; W_RESP on BVALID&BREADY -> W_IDLE.
REQ-025 Memory write commits on the edge that enters W_RESP; only bytes with WSTRB=1 change; BVALID rises the following cycle (1-cycle latency after last of AW/W).
REQ-026 Write miss: memory unchanged, BRESP=2'b10 (SLVERR); hit: BRESP=2'b00.
REQ-027 Read FSM states: R_IDLE (ARREADY=1), R_DATA (RVALID=1, ARREADY=0); AR handshake -> R_DATA; RVALID&RREADY -> R_IDLE.
REQ-028 RDATA/RRESP registered at AR acceptance, RVALID next cycle; read miss gives RDATA=0, RRESP=2'b10.
REQ-029 BVALID, BRESP, RVALID, RDATA, RRESP SHALL hold stable while not accepted.
REQ-030 Read and write channels operate independently; same-cycle AR and write commit to one word returns the pre-write value.
REQ-031 One outstanding write and one outstanding read maximum; max throughput one transfer per 2 cycles per direction.

Reset
REQ-032 Reset asserted (even mid-transaction): both FSMs to idle, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, all memory words 0; in-flight transaction dropped.
REQ-033 AWREADY, WREADY and ARREADY are registered and rise on the first clock edge after reset deassertion.

Structure
REQ-034 Package axi_lite_pkg SHALL hold response constants (OKAY, EXOKAY, SLVERR, DECERR) and the write/read state enums.
REQ-035 Storage SHALL be sub-module axi_lite_mem_array (byte-enable write port, registered read port, async clear).

Verification
REQ-036 AW+W same cycle, 0x10000080, data 0x00000001, strb 0xF, BREADY=1 -> BVALID next cycle with BRESP 0; read 0x10000080 -> RDATA 0x00000001, RRESP 0.
REQ-037 W (0xA5A5A5A5) 3 cycles before AW (0x10000088) -> WREADY low after W accepted, BVALID one cycle after AW; read-back 0xA5A5A5A5.
REQ-038 Word 0x11223344 at 0x1000008C, then write 0x0000BB00 strb 4'b0010 -> read 0x1122BB44.
REQ-039 Write/read 0x100000C0 and 0x1000007C -> BRESP 2'b10, RRESP 2'b10, RDATA 0; all in-range words unchanged.
REQ-040 RREADY and BREADY held low 5 cycles -> RVALID/RDATA and BVALID/BRESP stable, ARREADY/AWREADY low until acceptance.
REQ-041 S_AXI_ARESETN low while BVALID=1 -> BVALID 0 without waiting for a clock edge; read of any address afterwards returns 0.
